// File: rtl/fp32_unpack_aligner_pkg.sv
// Shared FP32 field widths, special-value constants and unpack helpers for the adder-tree front end.
package fp32_unpack_aligner_pkg;

    localparam int EXP_WIDTH   = 8;
    localparam int MANT_WIDTH  = 23;
    localparam int GUARD_BITS  = 3;
    localparam int SIG_WIDTH   = MANT_WIDTH + 1;
    localparam int EXT_WIDTH   = SIG_WIDTH + GUARD_BITS;
    localparam int ALIGN_WIDTH = 1 + MANT_WIDTH + 1 + GUARD_BITS;

    localparam logic [EXP_WIDTH-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]          QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [MANT_WIDTH-1:0] frac;
    } fp32_t;

    // Denormals and zero sit on the same binade as exponent field 1.
    function automatic logic [EXP_WIDTH-1:0] eff_exp(input logic [EXP_WIDTH-1:0] exp);
        return (exp == '0) ? EXP_WIDTH'(1) : exp;
    endfunction

endpackage

// File: rtl/fp32_lane_aligner.sv
// Combinational per-lane aligner: right-shifts a 24b significand with guard and sticky bits,
// then returns it as a signed two's-complement ALIGN_WIDTH mantissa.
module fp32_lane_aligner
    import fp32_unpack_aligner_pkg::*;
(
    input  logic                   i_sign,
    input  logic [SIG_WIDTH-1:0]   i_sig,
    input  logic [EXP_WIDTH-1:0]   i_shift,
    output logic [ALIGN_WIDTH-1:0] o_mant
);

    logic [EXT_WIDTH-1:0]   w_ext;
    logic [EXT_WIDTH-1:0]   w_mask;
    logic [EXT_WIDTH-1:0]   w_mag;
    logic                   w_sticky;
    logic [ALIGN_WIDTH-1:0] w_mag_ext;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        w_ext    = {i_sig, {GUARD_BITS{1'b0}}};
        w_mask   = '0;
        w_sticky = 1'b0;
        w_mag    = '0;
        if (i_shift >= EXP_WIDTH'(EXT_WIDTH)) begin
            // Everything shifted out: only the sticky bit can survive.
            w_mag = EXT_WIDTH'(i_sig != '0);
        end else begin
            w_mask   = (EXT_WIDTH'(1) << i_shift) - EXT_WIDTH'(1);
            w_sticky = |(w_ext & w_mask);
            w_mag    = (w_ext >> i_shift) | EXT_WIDTH'(w_sticky);
        end
        w_mag_ext = {1'b0, w_mag};
        o_mant    = i_sign ? -w_mag_ext : w_mag_ext;
    end

endmodule

// File: rtl/fp32_unpack_aligner.sv
// Two-stage FP32 unpack/align front end: max-exponent search, per-lane alignment, special-value flags.
// Build option: define FP32_DENORM_FLUSH_EN to flush exp==0 lanes to signed zero before alignment.
module fp32_unpack_aligner
    import fp32_unpack_aligner_pkg::*;
#(
    parameter int NUM_IN = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_IN*32-1:0]          in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_IN*ALIGN_WIDTH-1:0] out_mant,
    output logic [EXP_WIDTH-1:0]          out_exp,
    output logic                          out_nan,
    output logic                          out_inf,
    output logic                          out_inf_sg
);

    logic w_adv1;
    logic w_adv2;
    logic r_s1_valid;
    logic r_s2_valid;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    fp32_t                w_op      [NUM_IN];
    logic                 w_sign    [NUM_IN];
    logic [EXP_WIDTH-1:0] w_eeff    [NUM_IN];
    logic [SIG_WIDTH-1:0] w_sig     [NUM_IN];
    logic [EXP_WIDTH-1:0] w_emax;
    logic                 w_any_nan;
    logic                 w_inf_pos;
    logic                 w_inf_neg;

    always_comb begin
        w_emax    = '0;
        w_any_nan = 1'b0;
        w_inf_pos = 1'b0;
        w_inf_neg = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_op[i]   = fp32_t'(in_data[32*i +: 32]);
            w_sign[i] = w_op[i].sign;
            w_eeff[i] = eff_exp(w_op[i].exp);
`ifdef FP32_DENORM_FLUSH_EN
            w_sig[i]  = (w_op[i].exp == '0) ? '0 : {1'b1, w_op[i].frac};
`else
            w_sig[i]  = {w_op[i].exp != '0, w_op[i].frac};
`endif
            if (w_op[i].exp > w_emax) w_emax = w_op[i].exp;
            if (w_op[i].exp == EXP_MAX) begin
                if (w_op[i].frac != '0) w_any_nan = 1'b1;
                else if (w_op[i].sign)  w_inf_neg = 1'b1;
                else                    w_inf_pos = 1'b1;
            end
        end
    end

    logic                 r_s1_sign [NUM_IN];
    logic [EXP_WIDTH-1:0] r_s1_eeff [NUM_IN];
    logic [SIG_WIDTH-1:0] r_s1_sig  [NUM_IN];
    logic [EXP_WIDTH-1:0] r_s1_emax;
    logic [EXP_WIDTH-1:0] r_s1_emax_eff;
    logic                 r_s1_any_nan;
    logic                 r_s1_inf_pos;
    logic                 r_s1_inf_neg;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst)         r_s1_valid <= 1'b0;
        else if (w_adv1) r_s1_valid <= in_valid;
    end

    // NOTE: stage-1 payload has no reset; r_s1_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_adv1 && in_valid) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_s1_sign[i] <= w_sign[i];
                r_s1_eeff[i] <= w_eeff[i];
                r_s1_sig[i]  <= w_sig[i];
            end
            r_s1_emax     <= w_emax;
            r_s1_emax_eff <= eff_exp(w_emax);
            r_s1_any_nan  <= w_any_nan;
            r_s1_inf_pos  <= w_inf_pos;
            r_s1_inf_neg  <= w_inf_neg;
        end
    end

    logic [EXP_WIDTH-1:0]   w_shift     [NUM_IN];
    logic [ALIGN_WIDTH-1:0] w_lane_mant [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
        assign w_shift[g] = r_s1_emax_eff - r_s1_eeff[g];

        fp32_lane_aligner u_lane (
            .i_sign  (r_s1_sign[g]),
            .i_sig   (r_s1_sig[g]),
            .i_shift (w_shift[g]),
            .o_mant  (w_lane_mant[g])
        );
    end

    logic w_nan;
    logic w_inf;
    logic w_special;

    assign w_nan     = r_s1_any_nan || (r_s1_inf_pos && r_s1_inf_neg);
    assign w_inf     = (r_s1_inf_pos || r_s1_inf_neg) && !w_nan;
    assign w_special = w_nan || w_inf;

    logic [NUM_IN*ALIGN_WIDTH-1:0] r_s2_mant;
    logic [EXP_WIDTH-1:0]          r_s2_exp;
    logic                          r_s2_nan;
    logic                          r_s2_inf;
    logic                          r_s2_inf_sg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_mant   <= '0;
            r_s2_exp    <= '0;
            r_s2_nan    <= 1'b0;
            r_s2_inf    <= 1'b0;
            r_s2_inf_sg <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                // Special bundles carry a deterministic zero payload.
                for (int i = 0; i < NUM_IN; i++) begin
                    r_s2_mant[ALIGN_WIDTH*i +: ALIGN_WIDTH] <= w_special ? '0 : w_lane_mant[i];
                end
                r_s2_exp    <= w_special ? EXP_MAX : r_s1_emax;
                r_s2_nan    <= w_nan;
                r_s2_inf    <= w_inf;
                r_s2_inf_sg <= w_inf && r_s1_inf_neg;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_mant   = r_s2_mant;
    assign out_exp    = r_s2_exp;
    assign out_nan    = r_s2_nan;
    assign out_inf    = r_s2_inf;
    assign out_inf_sg = r_s2_inf_sg;

endmodule
